// File: rtl/demux1x4_rx_pkg.sv
// Shared types and constants for the 1:4 byte demultiplexer.
// DEMUX_FRAME_COUNT_EN enables the saturating frame counter.
package demux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int         NUM_LANES = 4;
  localparam logic [1:0] LAST_LANE = 2'd3;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/demux1x4_rx_if.sv
// Byte-stream input and lane-output bundle for demux1x4_rx.
// master drives the byte stream, slave is the demultiplexer.
interface demux1x4_rx_if #(
  parameter int BW = 8
);

  logic [BW-1:0] data_rx000;
  logic          valid_rx000;
  logic          active;

  logic [BW-1:0] data_0r;
  logic [BW-1:0] data_1r;
  logic [BW-1:0] data_2r;
  logic [BW-1:0] data_3r;
  logic          valid_0r;
  logic          valid_1r;
  logic          valid_2r;
  logic          valid_3r;
  logic          frame_strobe;
  logic [1:0]    lane_sel;
  logic [7:0]    frames_rcvd;

  modport master (
    output data_rx000,
    output valid_rx000,
    output active,
    input  data_0r,
    input  data_1r,
    input  data_2r,
    input  data_3r,
    input  valid_0r,
    input  valid_1r,
    input  valid_2r,
    input  valid_3r,
    input  frame_strobe,
    input  lane_sel,
    input  frames_rcvd
  );

  modport slave (
    input  data_rx000,
    input  valid_rx000,
    input  active,
    output data_0r,
    output data_1r,
    output data_2r,
    output data_3r,
    output valid_0r,
    output valid_1r,
    output valid_2r,
    output valid_3r,
    output frame_strobe,
    output lane_sel,
    output frames_rcvd
  );

endinterface

// File: rtl/demux1x4_rx_lane_counter.sv
// 2-bit wrapping lane index with synchronous clear and enable.
// Clear wins over enable.
module lane_counter (
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [1:0] cnt_o
);

  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 2'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/demux1x4_rx.sv
// 1:4 byte demultiplexer: stages lanes 0-2, publishes a frame on lane 3.
// DEMUX_FRAME_COUNT_EN adds a saturating completed-frame counter.
module demux1x4_rx
  import demux_pkg::*;
#(
  parameter int BW = 8
) (
  input  logic         clk_4f,
  input  logic         reset,
  demux1x4_rx_if.slave rx
);

  localparam int NSTG = NUM_LANES - 1;

  state_e        state_q;
  state_e        state_d;
  logic [1:0]    lane;
  logic          cap;
  logic          abort;
  logic          xfer;
  logic          stage;
  logic [BW-1:0] byte_in;

  logic [BW-1:0]   stg_data_q [NSTG];
  logic [BW-1:0]   stg_data_d [NSTG];
  logic [NSTG-1:0] stg_vld_q;
  logic [NSTG-1:0] stg_vld_d;

  logic [BW-1:0]        out_data_q [NUM_LANES];
  logic [BW-1:0]        out_data_d [NUM_LANES];
  logic [NUM_LANES-1:0] out_vld_q;
  logic [NUM_LANES-1:0] out_vld_d;
  logic                 strobe_q;
  logic                 strobe_d;

  // active is sampled before any capture, so a drop on lane 3 loses the frame
  assign cap     = (state_q == RUN) && rx.active;
  assign abort   = (state_q == RUN) && !rx.active;
  assign xfer    = cap && (lane == LAST_LANE);
  assign stage   = cap && (lane != LAST_LANE);
  assign byte_in = rx.valid_rx000 ? rx.data_rx000 : '0;

  lane_counter u_lane_counter (
    .clk_i (clk_4f),
    .clr_i (reset | ~cap),
    .en_i  (cap),
    .cnt_o (lane)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rx.active) state_d = RUN;
      RUN:     if (!rx.active) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    stg_data_d = stg_data_q;
    stg_vld_d  = stg_vld_q;
    out_data_d = out_data_q;
    out_vld_d  = out_vld_q;
    strobe_d   = 1'b0;
    unique case (1'b1)
      abort: begin
        stg_vld_d = '0;
      end
      xfer: begin
        for (int i = 0; i < NSTG; i++) begin
          out_data_d[i] = stg_data_q[i];
          out_vld_d[i]  = stg_vld_q[i];
        end
        out_data_d[LAST_LANE] = byte_in;
        out_vld_d[LAST_LANE]  = rx.valid_rx000;
        strobe_d              = 1'b1;
      end
      stage: begin
        for (int i = 0; i < NSTG; i++) begin
          if (lane == 2'(i)) begin
            stg_data_d[i] = byte_in;
            stg_vld_d[i]  = rx.valid_rx000;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      stg_data_q <= '{default: '0};
      stg_vld_q  <= '0;
      out_data_q <= '{default: '0};
      out_vld_q  <= '0;
      strobe_q   <= 1'b0;
    end else begin
      stg_data_q <= stg_data_d;
      stg_vld_q  <= stg_vld_d;
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
      strobe_q   <= strobe_d;
    end
  end

  assign rx.data_0r      = out_data_q[0];
  assign rx.data_1r      = out_data_q[1];
  assign rx.data_2r      = out_data_q[2];
  assign rx.data_3r      = out_data_q[3];
  assign rx.valid_0r     = out_vld_q[0];
  assign rx.valid_1r     = out_vld_q[1];
  assign rx.valid_2r     = out_vld_q[2];
  assign rx.valid_3r     = out_vld_q[3];
  assign rx.frame_strobe = strobe_q;
  assign rx.lane_sel     = lane;

`ifdef DEMUX_FRAME_COUNT_EN
  logic [7:0] frames_q;
  logic [7:0] frames_d;

  // counted on the transfer edge so the count moves with frame_strobe
  always_comb begin
    frames_d = frames_q;
    if (xfer) begin
      frames_d = sat_inc8(frames_q);
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      frames_q <= '0;
    end else begin
      frames_q <= frames_d;
    end
  end

  assign rx.frames_rcvd = frames_q;
`else
  assign rx.frames_rcvd = 8'h00;
`endif

endmodule

// File: tb/tb_demux1x4_rx.sv
// Directed bench for demux1x4_rx; honours DEMUX_FRAME_COUNT_EN.
module tb_demux1x4_rx;

`ifdef DEMUX_FRAME_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk_4f = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   exp_fr = 0;

  demux1x4_rx_if #(.BW(8)) bus ();

  demux1x4_rx #(.BW(8)) dut (
    .clk_4f (clk_4f),
    .reset  (reset),
    .rx     (bus)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic tick();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic v);
    bus.data_rx000  = d;
    bus.valid_rx000 = v;
    tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] outs();
    return {bus.data_3r, bus.data_2r, bus.data_1r, bus.data_0r};
  endfunction

  function automatic logic [31:0] vlds();
    return {28'd0, bus.valid_3r, bus.valid_2r, bus.valid_1r, bus.valid_0r};
  endfunction

  function automatic logic [31:0] efr();
    return CNT_EN ? ((exp_fr > 255) ? 32'hFF : 32'(exp_fr)) : 32'h0;
  endfunction

  initial begin
    logic [7:0] bb [8];
    int n_str;
    int s_first;
    int s_last;

    reset           = 1'b1;
    bus.active      = 1'b1;
    bus.data_rx000  = 8'hFF;
    bus.valid_rx000 = 1'b1;
    tick();
    tick();
    chk("rst_data", outs(), 32'h0);
    chk("rst_vld", vlds(), 32'h0);
    chk("rst_strobe", 32'(bus.frame_strobe), 32'h0);
    chk("rst_lane", 32'(bus.lane_sel), 32'h0);
    chk("rst_frames", 32'(bus.frames_rcvd), 32'h0);

    // first post-reset cycle is IDLE even with active high
    reset = 1'b0;
    tick();
    chk("post_rst_lane", 32'(bus.lane_sel), 32'h0);
    chk("post_rst_strobe", 32'(bus.frame_strobe), 32'h0);

    send(8'h11, 1'b1);
    chk("lane_after_b0", 32'(bus.lane_sel), 32'h1);
    send(8'h22, 1'b1);
    chk("lane_after_b1", 32'(bus.lane_sel), 32'h2);
    send(8'h33, 1'b1);
    chk("lane_after_b2", 32'(bus.lane_sel), 32'h3);
    chk("no_early_strobe", 32'(bus.frame_strobe), 32'h0);
    chk("hold_before_xfer", outs(), 32'h0);
    send(8'h44, 1'b1);
    exp_fr++;
    chk("f1_strobe", 32'(bus.frame_strobe), 32'h1);
    chk("f1_data", outs(), 32'h44332211);
    chk("f1_vld", vlds(), 32'hF);
    chk("f1_lane_wrap", 32'(bus.lane_sel), 32'h0);
    chk("f1_frames", 32'(bus.frames_rcvd), efr());

    bb = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    n_str   = 0;
    s_first = -1;
    s_last  = -1;
    for (int k = 0; k < 8; k++) begin
      send(bb[k], 1'b1);
      if (bus.frame_strobe) begin
        n_str++;
        if (s_first < 0) s_first = k;
        s_last = k;
      end
    end
    exp_fr += 2;
    chk("b2b_strobes", 32'(n_str), 32'd2);
    chk("b2b_first", 32'(s_first), 32'd3);
    chk("b2b_gap", 32'(s_last - s_first), 32'd4);
    chk("b2b_data", outs(), 32'hB3B2B1B0);
    chk("b2b_frames", 32'(bus.frames_rcvd), efr());

    send(8'h55, 1'b1);
    chk("strobe_one_cycle", 32'(bus.frame_strobe), 32'h0);
    chk("hold_between", outs(), 32'hB3B2B1B0);
    send(8'h66, 1'b1);
    send(8'h77, 1'b0);
    send(8'h88, 1'b1);
    exp_fr++;
    chk("inv_strobe", 32'(bus.frame_strobe), 32'h1);
    chk("inv_data", outs(), 32'h88006655);
    chk("inv_vld", vlds(), 32'hB);

    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    send(8'h44, 1'b1);
    exp_fr++;
    chk("f5_data", outs(), 32'h44332211);

    // drop active after lane 1 of the next frame
    send(8'h99, 1'b1);
    send(8'hAA, 1'b1);
    bus.active = 1'b0;
    send(8'hBB, 1'b1);
    chk("abort_strobe", 32'(bus.frame_strobe), 32'h0);
    chk("abort_lane", 32'(bus.lane_sel), 32'h0);
    chk("abort_data", outs(), 32'h44332211);
    chk("abort_vld", vlds(), 32'hF);
    send(8'hCC, 1'b1);
    chk("idle_lane", 32'(bus.lane_sel), 32'h0);
    chk("idle_strobe", 32'(bus.frame_strobe), 32'h0);

    bus.active = 1'b1;
    send(8'hDD, 1'b1);
    chk("reassert_lane", 32'(bus.lane_sel), 32'h0);
    send(8'hC0, 1'b1);
    send(8'hC1, 1'b1);
    send(8'hC2, 1'b1);
    send(8'hC3, 1'b1);
    exp_fr++;
    chk("realign_strobe", 32'(bus.frame_strobe), 32'h1);
    chk("realign_data", outs(), 32'hC3C2C1C0);
    chk("realign_frames", 32'(bus.frames_rcvd), efr());

    // drop active on the lane-3 cycle
    send(8'hD0, 1'b1);
    send(8'hD1, 1'b1);
    send(8'hD2, 1'b1);
    bus.active = 1'b0;
    send(8'hD3, 1'b1);
    chk("l3_abort_strobe", 32'(bus.frame_strobe), 32'h0);
    chk("l3_abort_data", outs(), 32'hC3C2C1C0);
    chk("l3_abort_frames", 32'(bus.frames_rcvd), efr());

    bus.active = 1'b1;
    send(8'h00, 1'b1);
    send(8'h5A, 1'b0);
    send(8'h5B, 1'b0);
    send(8'h5C, 1'b0);
    send(8'h5D, 1'b0);
    exp_fr++;
    chk("allinv_strobe", 32'(bus.frame_strobe), 32'h1);
    chk("allinv_data", outs(), 32'h0);
    chk("allinv_vld", vlds(), 32'h0);
    chk("allinv_frames", 32'(bus.frames_rcvd), efr());

    send(8'hE0, 1'b1);
    send(8'hE1, 1'b1);
    chk("pre_rst_lane", 32'(bus.lane_sel), 32'h2);
    reset = 1'b1;
    send(8'hE2, 1'b1);
    exp_fr = 0;
    chk("midrst_data", outs(), 32'h0);
    chk("midrst_vld", vlds(), 32'h0);
    chk("midrst_strobe", 32'(bus.frame_strobe), 32'h0);
    chk("midrst_lane", 32'(bus.lane_sel), 32'h0);
    chk("midrst_frames", 32'(bus.frames_rcvd), 32'h0);

    reset = 1'b0;
    tick();
    for (int f = 0; f < 260; f++) begin
      for (int b = 0; b < 4; b++) begin
        send(8'(f + b), 1'b1);
      end
      exp_fr++;
      if (f == 0) begin
        chk("sat_first", 32'(bus.frames_rcvd), efr());
      end
      if (f == 254) begin
        chk("sat_255", 32'(bus.frames_rcvd), efr());
      end
    end
    chk("sat_frames", 32'(bus.frames_rcvd), CNT_EN ? 32'hFF : 32'h0);
    chk("sat_data", outs(), {8'd6, 8'd5, 8'd4, 8'd3});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/demux1x4_rx.md
DEMUX1X4_RX -- requirements
Module: demux1x4_rx

Interface
REQ-001 Parameter: BW, default 8, byte width of every data port.
REQ-002 clk_4f  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk_4f.
REQ-004 data_rx000  input  BW  byte from serial-to-parallel converter, one per clk_4f.
REQ-005 valid_rx000  input  1  qualifies data_rx000.
REQ-006 active  input  1  converter alignment flag; 1 = byte stream is lane-aligned.
REQ-007 data_0r, data_1r, data_2r, data_3r  output  BW each  lane bytes of last completed frame.
REQ-008 valid_0r, valid_1r, valid_2r, valid_3r  output  1 each  lane valids of last completed frame.
REQ-009 frame_strobe  output  1  one-cycle pulse; lane outputs updated this cycle.
REQ-010 lane_sel  output  2  lane index assigned to the byte currently at the input.
REQ-011 frames_rcvd  output  8  completed-frame count (see Configuration).

Function
REQ-012 Block SHALL be a two-state FSM: IDLE and RUN.
REQ-013 IDLE -> RUN when active=1; RUN -> IDLE when active=0; no other transitions.
REQ-014 In IDLE, lane_sel SHALL be 0 and no byte SHALL be captured.
REQ-015 In RUN, lane_sel SHALL increment by 1 every clk_4f, wrapping 3 -> 0, regardless of valid_rx000.
REQ-016 The first RUN-cycle byte SHALL be lane 0.
REQ-017 Lanes 0-2 SHALL load internal staging registers (byte + valid).
REQ-018 A staged byte with valid_rx000=0 SHALL be stored as 8'h00 with valid 0.
REQ-019 On the lane-3 cycle, staging lanes 0-2 plus the input byte SHALL transfer to the lane outputs together.
REQ-020 frame_strobe SHALL be 1 for exactly one cycle after each transfer; lane outputs valid from that cycle.
REQ-021 Latency: lane-3 byte at input on edge N appears on data_3r after edge N+1; lane 0 after edge N+4 relative to its own capture.
REQ-022 Lane outputs SHALL hold between transfers.
REQ-023 active falling mid-frame SHALL discard the partial frame: staging valids cleared, no strobe, outputs keep last frame.
REQ-024 active falling in the lane-3 cycle SHALL discard that frame; active is sampled before capture.
REQ-025 A frame whose four valids are all 0 SHALL still transfer and strobe.

Reset
REQ-026 reset=1 SHALL force IDLE, lane_sel=0, all staging and lane outputs to 0, frame_strobe=0, frames_rcvd=0.
REQ-027 reset SHALL take priority over active and all data inputs in the same cycle.
REQ-028 After reset deasserts with active=1, the first post-reset cycle is IDLE and the next cycle is lane 0.

Configuration
REQ-029 Macro DEMUX_FRAME_COUNT_EN SHALL select the frame counter.
REQ-030 With DEMUX_FRAME_COUNT_EN defined, frames_rcvd SHALL increment with each frame_strobe and saturate at 8'hFF.
REQ-031 Without DEMUX_FRAME_COUNT_EN, frames_rcvd SHALL be tied to 8'h00 and no counter flops are inferred.

Structure
REQ-032 Shared package demux_pkg SHALL hold the FSM state encodings (IDLE=0, RUN=1), NUM_LANES=4 and LAST_LANE=3.
REQ-033 Sub-module lane_counter SHALL implement the 2-bit wrapping counter with synchronous clear and enable.
REQ-034 All other logic SHALL be in demux1x4_rx.

Verification
REQ-035 Reset, then active=1 with bytes 0x11,0x22,0x33,0x44 all valid -> one cycle after 0x44, data_0r..3r=11/22/33/44, valids=1111, frame_strobe pulses once.
REQ-036 Two back-to-back frames 0xA0-0xA3 and 0xB0-0xB3 -> exactly two strobes 4 cycles apart; outputs B0-B3 after the second.
REQ-037 Frame 0x55,0x66,0x77,0x88 with valid on byte 2 = 0 -> data_2r=0x00, valid_2r=0, other lanes as sent.
REQ-038 active dropped after lane 1 of a frame following a completed 0x11-0x44 frame -> no strobe, outputs remain 11/22/33/44, lane_sel=0; on re-assertion, the next byte lands in lane 0.
REQ-039 reset asserted on the lane-2 cycle -> all outputs 0 next cycle, frames_rcvd=0.
REQ-040 With DEMUX_FRAME_COUNT_EN, 260 consecutive frames -> frames_rcvd=0xFF; without the macro, frames_rcvd=0x00 throughout.
